// File: rtl/fp_round_norm_pkg.sv
// fp_pkg: rounding-mode codes and product-width helper for fp_round_norm.
package fp_pkg;
   localparam logic [1:0] RND_RNE = 2'd0;
   localparam logic [1:0] RND_RTZ = 2'd1;
   localparam logic [1:0] RND_RUP = 2'd2;
   localparam logic [1:0] RND_RDN = 2'd3;
   function automatic int prod_w(input int m);
      return 2 * (m + 1);
   endfunction
endpackage

// File: rtl/fp_round_norm_if.sv
// fp_round_norm_if: input/output handshake bundle; master drives operands and out_ready.
interface fp_round_norm_if #(parameter int M = 23, parameter int E = 8);
   localparam int P = fp_pkg::prod_w(M);
   logic                in_valid;
   logic                in_ready;
   logic [P-1:0]        in_product;
   logic signed [E+1:0] in_exp;
   logic                in_sign;
   logic [1:0]          in_rnd_mode;
   logic                out_valid;
   logic                out_ready;
   logic                out_sign;
   logic [E-1:0]        out_exp;
   logic [M-1:0]        out_mant;
   logic                out_inexact;
   logic                out_overflow;
   logic                out_underflow;
   modport master (
      output in_valid, in_product, in_exp, in_sign, in_rnd_mode, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow, out_underflow
   );
   modport slave (
      input  in_valid, in_product, in_exp, in_sign, in_rnd_mode, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_mant, out_inexact, out_overflow, out_underflow
   );
endinterface

// File: rtl/fp_round_norm_inc.sv
// fp_round_inc: combinational rounding increment with carry-out of the stored fraction.
module fp_round_inc
   import fp_pkg::*;
#(parameter int M = 23) (
   input  logic [M-1:0] i_frac,
   input  logic         i_guard,
   input  logic         i_sticky,
   input  logic         i_sign,
   input  logic [1:0]   i_mode,
   output logic [M-1:0] o_frac,
   output logic         o_carry,
   output logic         o_inc,
   output logic         o_inexact
);
   localparam int W = M + 1;
   logic w_lost;
   assign w_lost = i_guard | i_sticky;
   assign o_inc = (i_mode == RND_RNE) ? i_guard & (i_sticky | i_frac[0]) :
                  (i_mode == RND_RUP) ? ~i_sign & w_lost :
                  (i_mode == RND_RDN) ? i_sign & w_lost : 1'b0;
   assign {o_carry, o_frac} = {1'b0, i_frac} + W'(o_inc);
   assign o_inexact = w_lost;
endmodule

// File: rtl/fp_round_norm.sv
// fp_round_norm: two-stage normalise/round/saturate for the FP multiplier, valid/ready both sides.
// Define FP_ROUND_MODES_EN to honour in_rnd_mode; otherwise round-to-nearest-even is fixed.
module fp_round_norm
   import fp_pkg::*;
#(parameter int M = 23, parameter int E = 8) (
   input logic           clk,
   input logic           rst_n,
   fp_round_norm_if.slave bus
);
   localparam int P  = prod_w(M);
   localparam int XW = E + 3;
   localparam logic [XW-1:0] EXP_OVF  = XW'((1 << E) - 1);
   localparam logic [E-1:0]  EXP_MAXF = E'((1 << E) - 2);
   logic          w_top, w_guard, w_sticky, w_s2_load, w_accept;
   logic [M-1:0]  w_frac;
   logic [XW-1:0] w_exp;
   logic [1:0]    w_mode;
   logic          r_s1_valid, r_s1_guard, r_s1_sticky, r_s1_sign, r_s1_zero;
   logic [M-1:0]  r_s1_frac;
   logic [XW-1:0] r_s1_exp;
   logic [M-1:0]  w_rfrac;
   logic          w_carry, w_inc, w_inexact, w_ovf, w_unf, w_inf;
   logic [XW-1:0] w_exp2;
   logic          r_out_valid, r_out_sign, r_out_inexact, r_out_ovf, r_out_unf;
   logic [E-1:0]  r_out_exp;
   logic [M-1:0]  r_out_mant;
   assign w_top    = bus.in_product[P-1];
   assign w_frac   = w_top ? bus.in_product[P-2 -: M] : bus.in_product[P-3 -: M];
   assign w_guard  = w_top ? bus.in_product[P-2-M] : bus.in_product[P-3-M];
   assign w_sticky = w_top ? |bus.in_product[P-3-M:0] : |bus.in_product[P-4-M:0];
   // One extra exponent bit so +1 normalise and +1 round carry never wrap.
   assign w_exp    = {bus.in_exp[E+1], bus.in_exp} + XW'(w_top);
   assign w_s2_load    = !r_out_valid | bus.out_ready;
   assign bus.in_ready = !r_s1_valid | w_s2_load;
   assign w_accept     = bus.in_valid & bus.in_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_frac   <= '0;
         r_s1_guard  <= 1'b0;
         r_s1_sticky <= 1'b0;
         r_s1_exp    <= '0;
         r_s1_sign   <= 1'b0;
         r_s1_zero   <= 1'b0;
      end else if (bus.in_ready) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_frac   <= w_frac;
            r_s1_guard  <= w_guard;
            r_s1_sticky <= w_sticky;
            r_s1_exp    <= w_exp;
            r_s1_sign   <= bus.in_sign;
            r_s1_zero   <= bus.in_product == '0;
         end
      end
   end
`ifdef FP_ROUND_MODES_EN
   logic [1:0] r_s1_mode;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_s1_mode <= RND_RNE;
      else if (w_accept) r_s1_mode <= bus.in_rnd_mode;
   end
   assign w_mode = r_s1_mode;
`else
   assign w_mode = RND_RNE;
`endif
   fp_round_inc #(.M(M)) u_inc (
      .i_frac(r_s1_frac), .i_guard(r_s1_guard), .i_sticky(r_s1_sticky), .i_sign(r_s1_sign),
      .i_mode(w_mode), .o_frac(w_rfrac), .o_carry(w_carry), .o_inc(w_inc), .o_inexact(w_inexact)
   );
   assign w_exp2 = r_s1_exp + XW'(w_inc & w_carry);
   assign w_unf  = w_exp2[XW-1] | (w_exp2 == '0);
   assign w_ovf  = !w_exp2[XW-1] & (w_exp2 >= EXP_OVF);
   // Overflow goes to infinity only when the mode rounds away from zero for this sign.
   assign w_inf  = (w_mode == RND_RNE) | (w_mode == RND_RUP & !r_s1_sign) | (w_mode == RND_RDN & r_s1_sign);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_sign    <= 1'b0;
         r_out_exp     <= '0;
         r_out_mant    <= '0;
         r_out_inexact <= 1'b0;
         r_out_ovf     <= 1'b0;
         r_out_unf     <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_sign    <= r_s1_sign;
            r_out_exp     <= (r_s1_zero | w_unf) ? '0 : w_ovf ? (w_inf ? '1 : EXP_MAXF) : w_exp2[E-1:0];
            r_out_mant    <= (r_s1_zero | w_unf | (w_ovf & w_inf)) ? '0 : w_ovf ? '1 : w_rfrac;
            r_out_ovf     <= !r_s1_zero & w_ovf;
            r_out_unf     <= !r_s1_zero & w_unf;
            r_out_inexact <= !r_s1_zero & (w_ovf | w_unf | w_inexact);
         end
      end
   end
   assign bus.out_valid     = r_out_valid;
   assign bus.out_sign      = r_out_sign;
   assign bus.out_exp       = r_out_exp;
   assign bus.out_mant      = r_out_mant;
   assign bus.out_inexact   = r_out_inexact;
   assign bus.out_overflow  = r_out_ovf;
   assign bus.out_underflow = r_out_unf;
endmodule

// File: tb/tb_fp_round_norm.sv
// tb_fp_round_norm: vector table, back-pressure, random scoreboard and mid-stream reset for fp_round_norm.
module tb_fp_round_norm;
   import fp_pkg::*;
   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      logic        inx;
      logic        ovf;
      logic        unf;
   } res_t;
   typedef struct {
      logic [47:0] p;
      logic [9:0]  e;
      logic        s;
      logic [1:0]  rm;
      res_t        want;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_out = 0;
   bit   sb_en = 1'b0;
   res_t q[$];
   vec_t tab[$];
   fp_round_norm_if #(.M(23), .E(8)) bus();
   fp_round_norm #(.M(23), .E(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endfunction
   function automatic res_t dut_res();
      return {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inexact, bus.out_overflow, bus.out_underflow};
   endfunction
   // Reference: value-level rounding of the integer significand, then range saturation.
   function automatic res_t model(input logic [47:0] p, input logic [9:0] e, input logic s, input logic [1:0] rm_in);
      res_t r;
      int sh, x;
      longint sig, rem, half;
      logic [1:0] rm;
      bit up, inf;
      rm = rm_in;
`ifndef FP_ROUND_MODES_EN
      rm = RND_RNE;
`endif
      r = '0;
      r.s = s;
      if (p == '0) return r;
      sh = p[47] ? 24 : 23;
      sig = longint'(p >> sh);
      rem = longint'(p) - (sig << sh);
      half = longint'(1) << (sh - 1);
      x = int'($signed(e)) + (p[47] ? 1 : 0);
      up = (rm == RND_RNE) ? (rem > half || (rem == half && sig[0])) :
           (rm == RND_RUP) ? (!s && rem != 0) :
           (rm == RND_RDN) ? (s && rem != 0) : 1'b0;
      sig = sig + longint'(up);
      if (sig == (longint'(1) << 24)) begin
         sig = sig >> 1;
         x++;
      end
      if (x >= 255) begin
         inf = (rm == RND_RNE) || (rm == RND_RUP && !s) || (rm == RND_RDN && s);
         r.ovf = 1'b1;
         r.inx = 1'b1;
         r.e = inf ? 8'hFF : 8'hFE;
         r.m = inf ? 23'h0 : 23'h7FFFFF;
      end else if (x <= 0) begin
         r.unf = 1'b1;
         r.inx = 1'b1;
      end else begin
         r.e = x[7:0];
         r.m = sig[22:0];
         r.inx = rem != 0;
      end
      return r;
   endfunction
   function automatic vec_t mkv(input logic [47:0] p, input int e, input logic s, input logic [1:0] rm,
                                input logic os, input logic [7:0] oe, input logic [22:0] om,
                                input logic inx, input logic ovf, input logic unf);
      vec_t v;
      v.p = p;
      v.e = e[9:0];
      v.s = s;
      v.rm = rm;
      v.want = {os, oe, om, inx, ovf, unf};
      return v;
   endfunction
   task automatic set_in(input logic [47:0] p, input logic [9:0] e, input logic s, input logic [1:0] rm);
      bus.in_product = p;
      bus.in_exp = e;
      bus.in_sign = s;
      bus.in_rnd_mode = rm;
   endtask
   task automatic rand_in();
      logic [63:0] r;
      int ei;
      r = {$urandom(), $urandom()};
      if (!r[47]) r[46] = 1'b1;
      if ($urandom_range(0, 3) == 0) r[22:0] = r[47] ? 23'd0 : {r[22], 22'd0};
      if ($urandom_range(0, 7) == 0) begin
         if (r[47]) r[46:24] = '1;
         else r[45:23] = '1;
      end
      if ($urandom_range(0, 15) == 0) r = '0;
      ei = int'($urandom_range(0, 265)) - 5;
      set_in(r[47:0], ei[9:0], 1'($urandom() & 1), 2'($urandom_range(0, 3)));
   endtask
   always @(negedge clk) begin
      if (rst_n && sb_en) begin
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL sb_unexpected: got output %0h expected none", dut_res());
            end else chk("sb_data", dut_res(), q.pop_front());
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.in_product, bus.in_exp, bus.in_sign, bus.in_rnd_mode));
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      int lat, idx, nv;
      bit acc;
      res_t hold;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      set_in('0, '0, 1'b0, RND_RNE);
      tab.push_back(mkv(48'h900000000000, 127, 1'b0, RND_RNE, 1'b0, 8'd128, 23'h100000, 1'b0, 1'b0, 1'b0));
      tab.push_back(mkv(48'h400000400000, 100, 1'b0, RND_RNE, 1'b0, 8'd100, 23'h0, 1'b1, 1'b0, 1'b0));
      tab.push_back(mkv(48'h400000C00000, 100, 1'b0, RND_RNE, 1'b0, 8'd100, 23'h2, 1'b1, 1'b0, 1'b0));
      tab.push_back(mkv(48'h7FFFFFC00000, 100, 1'b0, RND_RNE, 1'b0, 8'd101, 23'h0, 1'b1, 1'b0, 1'b0));
      tab.push_back(mkv(48'h400000000000, 255, 1'b0, RND_RNE, 1'b0, 8'hFF, 23'h0, 1'b1, 1'b1, 1'b0));
      tab.push_back(mkv(48'h400000000000, 0, 1'b1, RND_RNE, 1'b1, 8'h0, 23'h0, 1'b1, 1'b0, 1'b1));
      tab.push_back(mkv(48'h000000000000, 50, 1'b1, RND_RNE, 1'b1, 8'h0, 23'h0, 1'b0, 1'b0, 1'b0));
      tab.push_back(mkv(48'h800000000001, 10, 1'b0, RND_RNE, 1'b0, 8'd11, 23'h0, 1'b1, 1'b0, 1'b0));
      tab.push_back(mkv(48'h800000800001, 10, 1'b0, RND_RNE, 1'b0, 8'd11, 23'h1, 1'b1, 1'b0, 1'b0));
      tab.push_back(mkv(48'hFFFFFFFFFFFF, 253, 1'b0, RND_RNE, 1'b0, 8'hFF, 23'h0, 1'b1, 1'b1, 1'b0));
      tab.push_back(mkv(48'h400000000000, 1, 1'b0, RND_RNE, 1'b0, 8'd1, 23'h0, 1'b0, 1'b0, 1'b0));
      tab.push_back(mkv(48'h800000000000, -1, 1'b0, RND_RNE, 1'b0, 8'd0, 23'h0, 1'b1, 1'b0, 1'b1));
      tab.push_back(mkv(48'h800000000000, 0, 1'b0, RND_RNE, 1'b0, 8'd1, 23'h0, 1'b0, 1'b0, 1'b0));
      tab.push_back(mkv(48'h400000000000, 254, 1'b0, RND_RNE, 1'b0, 8'd254, 23'h0, 1'b0, 1'b0, 1'b0));
      tab.push_back(mkv(48'h400000600000, 100, 1'b0, RND_RNE, 1'b0, 8'd100, 23'h1, 1'b1, 1'b0, 1'b0));
`ifdef FP_ROUND_MODES_EN
      tab.push_back(mkv(48'h400000000000, 255, 1'b0, RND_RTZ, 1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b1, 1'b0));
      tab.push_back(mkv(48'h400000000000, 255, 1'b1, RND_RUP, 1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b1, 1'b0));
      tab.push_back(mkv(48'h400000000000, 255, 1'b1, RND_RDN, 1'b1, 8'hFF, 23'h0, 1'b1, 1'b1, 1'b0));
      tab.push_back(mkv(48'h400000000001, 100, 1'b0, RND_RUP, 1'b0, 8'd100, 23'h1, 1'b1, 1'b0, 1'b0));
      tab.push_back(mkv(48'h400000000001, 100, 1'b1, RND_RDN, 1'b1, 8'd100, 23'h1, 1'b1, 1'b0, 1'b0));
      tab.push_back(mkv(48'h400000000001, 100, 1'b0, RND_RDN, 1'b0, 8'd100, 23'h0, 1'b1, 1'b0, 1'b0));
      tab.push_back(mkv(48'h400000C00000, 100, 1'b0, RND_RTZ, 1'b0, 8'd100, 23'h1, 1'b1, 1'b0, 1'b0));
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_fields", dut_res(), 0);
      rst_n = 1'b1;
      // Directed vectors, one at a time, also measuring accept-to-valid latency.
      foreach (tab[i]) begin
         @(posedge clk);
         #1;
         set_in(tab[i].p, tab[i].e, tab[i].s, tab[i].rm);
         bus.in_valid = 1'b1;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         lat = 1;
         while (!bus.out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
         end
         chk($sformatf("tab%0d_latency", i), lat, 2);
         chk($sformatf("tab%0d_result", i), dut_res(), tab[i].want);
      end
      // Back-pressure: four beats, out_ready low for the first five cycles.
      @(posedge clk);
      #1;
      sb_en = 1'b1;
      n_out = 0;
      idx = 0;
      bus.out_ready = 1'b0;
      rand_in();
      bus.in_valid = 1'b1;
      for (int c = 0; c < 40 && (idx < 4 || q.size() != 0); c++) begin
         if (c == 5) bus.out_ready = 1'b1;
         @(negedge clk);
         if (c == 2) begin
            hold = dut_res();
            chk("bp_in_ready_low", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
         end
         if (c == 3 || c == 4) begin
            chk("bp_hold_stable", dut_res(), hold);
            chk("bp_in_ready_low", bus.in_ready, 0);
         end
         if (c == 5) chk("bp_in_ready_return", bus.in_ready, 1);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            if (idx < 4) rand_in();
            else bus.in_valid = 1'b0;
         end
      end
      chk("bp_beats_in", idx, 4);
      chk("bp_beats_out", n_out, 4);
      chk("bp_queue_empty", q.size(), 0);
      // Random traffic with random stalls on both sides.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc || !bus.in_valid) begin
            bus.in_valid = $urandom_range(0, 3) != 0;
            rand_in();
         end
         bus.out_ready = $urandom_range(0, 3) != 0;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
      #1;
      chk("rand_drain", q.size(), 0);
      // Reset asserted between edges while both stages hold beats.
      rand_in();
      bus.in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         rand_in();
      end
      chk("mid_pre_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_fields", dut_res(), 0);
      q.delete();
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      nv = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.out_valid) nv++;
      end
      chk("mid_no_partial", nv, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fp_round_norm.md
# fp_round_norm

Pipelined normalise-and-round stage for the floating-point multiplier datapath, parametrised in mantissa and exponent width. It sits after the mantissa multiplier and exponent adder. It takes the raw 2(M+1)-bit significand product, the pre-normalisation exponent and the sign, and returns a packed, rounded result with status flags. It computes proper guard/sticky bits, handles rounding carry-out renormalisation, and saturates on exponent overflow and underflow. A valid/ready handshake allows back-pressure.

## Interface
- M, 23, stored fraction bits; product width P = 2*(M+1)
- E, 8, stored exponent bits
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts input this cycle
- in_product  in  P  unsigned significand product, both operands with hidden 1
- in_exp  in  E+2  signed two's-complement biased exponent: ea + eb − bias, before normalisation
- in_sign  in  1  result sign
- in_rnd_mode  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (−inf)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- out_sign, out_exp[E-1:0], out_mant[M-1:0]  out  result fields
- out_inexact, out_overflow, out_underflow  out  1 each  status flags

## Operation
- **Stage 1 (normalise)**, registered:
  - If in_product[P-1] = 1: frac = in_product[P-2 -: M], guard = in_product[P-2-M], sticky = OR of in_product[P-3-M:0], exp = in_exp + 1.
  - Else: frac = in_product[P-3 -: M], guard = in_product[P-3-M], sticky = OR of in_product[P-4-M:0], exp = in_exp.
  - Sticky is a reduction OR, never XOR.
  - in_product = 0 sets a zero tag.
  - in_rnd_mode is captured with the beat.
- **Stage 2 (round)**, registered:
  - Increment decision:
    - RNE: guard & (sticky | frac[0]).
    - RTZ: 0.
    - RUP: ~sign & (guard | sticky).
    - RDN: sign & (guard | sticky).
  - If frac is all ones and increment = 1: frac becomes 0 and exp + 1.
  - inexact = guard | sticky.
- **Exception handling**, applied after rounding:
  - exp ≥ 2^E − 1 sets overflow and inexact.
    - For RNE, RUP with sign=0, and RDN with sign=1: out_exp = all ones, out_mant = 0 (infinity).
    - Otherwise: max finite value, exp = 2^E − 2, mant = all ones.
  - exp ≤ 0 (signed) sets underflow. Output is flushed to ±0: out_exp = 0, out_mant = 0. inexact is set if any bit was discarded.
  - Zero tag: out_exp = 0, out_mant = 0, all flags 0. Sign is passed through.
- **Handshake:**
  - An input beat is accepted when in_valid & in_ready.
  - An output beat is consumed when out_valid & out_ready.
  - Stage 2 loads when !out_valid | out_ready.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid | !out_valid | out_ready (combinational).
  - Outputs stay stable while out_valid & !out_ready.

## Timing
- Latency: 2 cycles from acceptance to out_valid, with no stall.
- Throughput: 1 beat per cycle.
- Reset: all valid bits are 0, out_valid = 0, and every out_* data field and flag is 0.
- Reset asserted mid-operation discards both stages immediately. No partial beat is emitted after deassertion.
- Simultaneous accept and consume while both stages are full: both stages shift, so there is no bubble.
- out_ready held low for N cycles: at most 2 beats are held. in_ready falls once both stages are full and rises in the same cycle out_ready returns.

## Configuration
- FP_ROUND_MODES_EN:
  - Defined: in_rnd_mode is honoured as above.
  - Undefined: in_rnd_mode is ignored and RNE is hard-wired. The port remains, and the stage 1 mode register is removed.

## Structure
- Package fp_pkg holds:
  - rounding-mode localparams: RND_RNE, RND_RTZ, RND_RUP, RND_RDN
  - width helper P = 2*(M+1)
- Sub-module fp_round_inc (combinational) takes frac, guard, sticky, sign and mode. It returns the rounded frac, carry-out, increment and inexact. It is instantiated in stage 2.

## Test plan
- 1.5×1.5: in_product = 0x900000000000, in_exp = 127, RNE → out_exp = 128, out_mant = 0x100000, no flags, out_valid two cycles after acceptance.
- RNE tie, bit 47 = 0, frac LSB = 0, guard = 1, sticky = 0 → no increment, inexact = 1. Same with LSB = 1 → increment by 1.
- Carry-out: frac = 0x7FFFFF, guard = 1, RNE, in_exp = 100 → out_mant = 0, out_exp = 101.
- Overflow: in_exp = 255, bit 47 = 0, RNE → exp = 0xFF, mant = 0, overflow = 1. RTZ → exp = 0xFE, mant = 0x7FFFFF (requires FP_ROUND_MODES_EN).
- Underflow, in_exp = 0: → ±0, underflow = 1. Zero product: → exp = 0, mant = 0, no flags.
- Back-pressure: stream 4 beats with out_ready low for 3 cycles. in_ready must fall after 2 beats are held. All 4 beats must emerge in order with no drop or duplicate. Assert rst_n low mid-stream → out_valid = 0 on the same edge.
